mult_operand_sequencer: RTL and testbench



---
 rtl/mult_pkg.sv | 22 ++
 rtl/mult_operand_sequencer_if.sv | 31 +++
 rtl/btn_debounce.sv | 59 +++++
 rtl/mult_operand_sequencer.sv | 99 +++++++++
 tb/tb_mult_operand_sequencer.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier operand sequencer.
//   W                      : operand/result width, must match the multiplier
//   DebounceCyclesDefault  : stable cycles before a button level changes (10 ms at 50 MHz)
//   state_e                : sequencer FSM states; encodings double as the LED state_code
package mult_pkg;

  localparam int unsigned W = 4;
  localparam int unsigned DebounceCyclesDefault = 500000;

  localparam logic [1:0] StateCodeWaitA = 2'b00;
  localparam logic [1:0] StateCodeWaitB = 2'b01;
  localparam logic [1:0] StateCodeCalc  = 2'b10;
  localparam logic [1:0] StateCodeShow  = 2'b11;

  typedef enum logic [1:0] {
    StWaitA = StateCodeWaitA,
    StWaitB = StateCodeWaitB,
    StCalc  = StateCodeCalc,
    StShow  = StateCodeShow
  } state_e;

endpackage

// File: rtl/mult_operand_sequencer_if.sv
// Board-side bundle between the buttons/switches/multiplier and the sequencer.
//   sw, btn_enter, btn_clear : raw board inputs
//   prod                     : combinational product from the external multiplier
//   op_a, op_b               : operands driven into the multiplier
//   result, result_valid     : registered product for the display
//   state_code               : FSM state for LEDs
// master = board/multiplier side, slave = sequencer.
interface mult_operand_sequencer_if;
  import mult_pkg::*;

  logic [W-1:0] sw;
  logic         btn_enter;
  logic         btn_clear;
  logic [W-1:0] prod;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [W-1:0] result;
  logic         result_valid;
  logic [1:0]   state_code;

  modport master (
    output sw, btn_enter, btn_clear, prod,
    input  op_a, op_b, result, result_valid, state_code
  );

  modport slave (
    input  sw, btn_enter, btn_clear, prod,
    output op_a, op_b, result, result_valid, state_code
  );

endinterface

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-FF synchronizer, stability counter, rising-edge pulse.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   btn_i        : raw asynchronous bouncy button
//   level_o      : debounced level
//   pulse_o      : one-cycle pulse on each debounced 0->1 transition
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = mult_pkg::DebounceCyclesDefault
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic level_o,
  output logic pulse_o
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic            pulse_q, pulse_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Any cycle where the synchronized input agrees with the debounced level
  // restarts the count, so bounces never accumulate.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    pulse_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CntMax) begin
        level_d = ~level_q;
        pulse_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign pulse_o = pulse_q;

endmodule

// File: rtl/mult_operand_sequencer.sv
// Captures operand A then B from the switches on ENTER presses, registers the
// external multiplier's product, and clears everything on CLEAR.
//   clk, rst : clock, asynchronous active-high reset
//   bus_io   : slave side of mult_operand_sequencer_if (switches, buttons,
//              operands, product, result, result_valid, state_code)
module mult_operand_sequencer
  import mult_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesDefault
) (
  input  logic                     clk,
  input  logic                     rst,
  mult_operand_sequencer_if.slave  bus_io
);

  logic         enter_pulse, clear_pulse;
  state_e       state_q, state_d;
  logic [W-1:0] op_a_q, op_a_d;
  logic [W-1:0] op_b_q, op_b_d;
  logic [W-1:0] result_q, result_d;
  logic         valid_q, valid_d;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
    .clk_i   (clk),
    .rst_i   (rst),
    .btn_i   (bus_io.btn_enter),
    .level_o (),
    .pulse_o (enter_pulse)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
    .clk_i   (clk),
    .rst_i   (rst),
    .btn_i   (bus_io.btn_clear),
    .level_o (),
    .pulse_o (clear_pulse)
  );

  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    result_d = result_q;
    valid_d  = valid_q;
    // Clear overrides everything, including a coincident enter pulse.
    if (clear_pulse) begin
      state_d  = StWaitA;
      op_a_d   = '0;
      op_b_d   = '0;
      result_d = '0;
      valid_d  = 1'b0;
    end else begin
      case (state_q)
        StWaitA: if (enter_pulse) begin
          op_a_d  = bus_io.sw;
          state_d = StWaitB;
        end
        StWaitB: if (enter_pulse) begin
          op_b_d  = bus_io.sw;
          state_d = StCalc;
        end
        // Operands have settled through the multiplier by now; sample once.
        StCalc: begin
          result_d = bus_io.prod;
          valid_d  = 1'b1;
          state_d  = StShow;
        end
        StShow: if (enter_pulse) begin
          valid_d = 1'b0;
          state_d = StWaitA;
        end
        default: state_d = StWaitA;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StWaitA;
      op_a_q   <= '0;
      op_b_q   <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign bus_io.op_a         = op_a_q;
  assign bus_io.op_b         = op_b_q;
  assign bus_io.result       = result_q;
  assign bus_io.result_valid = valid_q;
  assign bus_io.state_code   = state_q;

endmodule

// File: tb/tb_mult_operand_sequencer.sv
// Directed bench for mult_operand_sequencer with DEBOUNCE_CYCLES = 4.
module tb_mult_operand_sequencer;
  import mult_pkg::*;

  logic clk;
  logic rst;
  int   err_cnt = 0;
  int   chk_cnt = 0;

  mult_operand_sequencer_if bus ();

  // Board-level circular multiplier: 4-bit result is the product mod 16.
  assign bus.prod = bus.op_a * bus.op_b;

  mult_operand_sequencer #(.DEBOUNCE_CYCLES(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Hold the chosen buttons for 'hold' cycles, release, then let things settle.
  task automatic press(input logic enter, input logic clear, input int hold);
    @(negedge clk);
    bus.btn_enter = enter;
    bus.btn_clear = clear;
    repeat (hold) @(negedge clk);
    bus.btn_enter = 1'b0;
    bus.btn_clear = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  // Raise ENTER and count negedges until state_code reaches target (bounded).
  task automatic press_until(input logic [1:0] target, output int n);
    @(negedge clk);
    bus.btn_enter = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (bus.state_code == target) break;
    end
  endtask

  task automatic release_enter();
    bus.btn_enter = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  int n;

  initial begin
    rst = 1'b0;
    bus.sw = '0;
    bus.btn_enter = 1'b0;
    bus.btn_clear = 1'b0;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_op_a", 8'(bus.op_a), 8'h0);
    check_eq("rst_op_b", 8'(bus.op_b), 8'h0);
    check_eq("rst_result", 8'(bus.result), 8'h0);
    check_eq("rst_valid", 8'(bus.result_valid), 8'h0);
    check_eq("rst_state", 8'(bus.state_code), 8'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 3 x 5 with latency checks: pulse after 2+4 edges, load on the 7th.
    bus.sw = 4'd3;
    press_until(2'b01, n);
    check_eq("a_latency", 8'(n), 8'd7);
    check_eq("a_op_a", 8'(bus.op_a), 8'h3);
    release_enter();
    bus.sw = 4'd5;
    press_until(2'b10, n);
    check_eq("b_latency", 8'(n), 8'd7);
    check_eq("b_op_b", 8'(bus.op_b), 8'h5);
    check_eq("calc_valid", 8'(bus.result_valid), 8'h0);
    @(negedge clk);
    check_eq("show_state", 8'(bus.state_code), 8'h3);
    check_eq("show_valid", 8'(bus.result_valid), 8'h1);
    check_eq("result_3x5", 8'(bus.result), 8'hF);
    release_enter();
    check_eq("hold_state", 8'(bus.state_code), 8'h3);
    // Switch changes outside a press are ignored.
    bus.sw = 4'd12;
    repeat (5) @(negedge clk);
    check_eq("sw_idle_op_a", 8'(bus.op_a), 8'h3);
    check_eq("sw_idle_result", 8'(bus.result), 8'hF);

    // Back to WAIT_A, then 7 x 6 = 42 -> 0xA.
    press(1'b1, 1'b0, 10);
    check_eq("back_state", 8'(bus.state_code), 8'h0);
    check_eq("back_valid", 8'(bus.result_valid), 8'h0);
    bus.sw = 4'd7;
    press(1'b1, 1'b0, 10);
    bus.sw = 4'd6;
    press(1'b1, 1'b0, 10);
    check_eq("result_7x6", 8'(bus.result), 8'hA);
    check_eq("valid_7x6", 8'(bus.result_valid), 8'h1);
    press(1'b1, 1'b0, 10);
    check_eq("next_valid", 8'(bus.result_valid), 8'h0);
    check_eq("next_state", 8'(bus.state_code), 8'h0);
    check_eq("next_op_a", 8'(bus.op_a), 8'h7);
    check_eq("next_result", 8'(bus.result), 8'hA);

    // 3-cycle glitch is too short; a 50-cycle hold gives exactly one pulse.
    bus.sw = 4'd9;
    press(1'b1, 1'b0, 3);
    check_eq("glitch_state", 8'(bus.state_code), 8'h0);
    check_eq("glitch_op_a", 8'(bus.op_a), 8'h7);
    press(1'b1, 1'b0, 50);
    check_eq("held_state", 8'(bus.state_code), 8'h1);
    check_eq("held_op_a", 8'(bus.op_a), 8'h9);

    // CLEAR from WAIT_B.
    press(1'b0, 1'b1, 10);
    check_eq("clr_op_a", 8'(bus.op_a), 8'h0);
    check_eq("clr_state", 8'(bus.state_code), 8'h0);
    check_eq("clr_result", 8'(bus.result), 8'h0);

    // CLEAR and ENTER debounce in the same cycle: clear wins.
    bus.sw = 4'd5;
    press(1'b1, 1'b1, 10);
    check_eq("both_state", 8'(bus.state_code), 8'h0);
    check_eq("both_op_a", 8'(bus.op_a), 8'h0);

    // Asynchronous reset landing mid-cycle while in CALC.
    bus.sw = 4'd2;
    press(1'b1, 1'b0, 10);
    bus.sw = 4'd3;
    press_until(2'b10, n);
    check_eq("pre_rst_state", 8'(bus.state_code), 8'h2);
    #1 rst = 1'b1;
    #1;
    check_eq("arst_op_a", 8'(bus.op_a), 8'h0);
    check_eq("arst_op_b", 8'(bus.op_b), 8'h0);
    check_eq("arst_result", 8'(bus.result), 8'h0);
    check_eq("arst_valid", 8'(bus.result_valid), 8'h0);
    check_eq("arst_state", 8'(bus.state_code), 8'h0);
    bus.btn_enter = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("post_rst_state", 8'(bus.state_code), 8'h0);
    bus.sw = 4'd2;
    press(1'b1, 1'b0, 10);
    bus.sw = 4'd3;
    press(1'b1, 1'b0, 10);
    check_eq("result_2x3", 8'(bus.result), 8'h6);
    check_eq("valid_2x3", 8'(bus.result_valid), 8'h1);
    check_eq("state_2x3", 8'(bus.state_code), 8'h3);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
